// File: rtl/dbi_decode_128b.sv
// Receive-side DBI decoder: restores the payload at accept, buffers it in a
// 2-entry skid buffer and keeps encoded-bus toggle/word statistics.
module dbi_decode_128b #(
   parameter int BW    = 128,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dbi_en,
   input  logic             in_valid,
   input  logic [BW:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [BW-1:0]    out_data,
   input  logic             out_ready,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic [CNT_W-1:0] word_cnt,
   output logic             err_flag
);

   localparam int PW = $clog2(BW + 2);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [SW-1:0] CMAX = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_t;

   state_t            state_q, state_d;
   logic [BW-1:0]     head_q, head_d;
   logic [BW-1:0]     tail_q, tail_d;
   logic [BW:0]       prev_q, prev_d;
   logic [CNT_W-1:0]  tog_q, tog_d;
   logic [CNT_W-1:0]  word_q, word_d;
   logic              err_q, err_d;

   logic              acc;
   logic              pop;
   logic [BW-1:0]     dec;
   logic [BW:0]       diff;
   logic [PW-1:0]     pc;
   logic [CNT_W-1:0]  tog_base;
   logic [CNT_W-1:0]  word_base;
   logic [SW-1:0]     tog_sum;
   logic [SW-1:0]     word_sum;

   assign in_ready   = (state_q != FULL);
   assign out_valid  = (state_q != EMPTY);
   assign out_data   = head_q;
   assign toggle_cnt = tog_q;
   assign word_cnt   = word_q;
   assign err_flag   = err_q;

   assign acc = in_valid && in_ready;
   assign pop = out_valid && out_ready;

   assign dec = (dbi_en && in_data[BW]) ? ~in_data[BW-1:0]
                                        : in_data[BW-1:0];

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      unique case (state_q)
         EMPTY: begin
            if (acc) begin
               head_d  = dec;
               state_d = ONE;
            end
         end
         ONE: begin
            if (acc && pop) begin
               head_d = dec;
            end else if (acc) begin
               tail_d  = dec;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      diff = in_data ^ prev_q;
      pc   = '0;
      for (int i = 0; i <= BW; i++) begin
         pc = pc + PW'(diff[i]);
      end
   end

   // A clear coinciding with an accept keeps only that word's contribution.
   always_comb begin
      prev_d    = prev_q;
      tog_base  = stats_clr ? '0 : tog_q;
      word_base = stats_clr ? '0 : word_q;
      tog_sum   = SW'(tog_base) + SW'(pc);
      word_sum  = SW'(word_base) + SW'(1);
      tog_d     = tog_base;
      word_d    = word_base;
      err_d     = stats_clr ? 1'b0 : err_q;
      if (acc) begin
         prev_d = in_data;
         tog_d  = (tog_sum > CMAX) ? '1 : tog_sum[CNT_W-1:0];
         word_d = (word_sum > CMAX) ? '1 : word_sum[CNT_W-1:0];
         if (!dbi_en && in_data[BW]) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         prev_q  <= '0;
         tog_q   <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         prev_q  <= prev_d;
         tog_q   <= tog_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dbi_decode_128b.sv
// Self-checking bench for dbi_decode_128b: directed steps with random data,
// checked against a queue-based reference model (32-bit and 8-bit counters).
module tb_dbi_decode_128b;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         dbi_en = 1'b0;
   logic         in_valid = 1'b0;
   logic [128:0] in_data = '0;
   logic         out_ready = 1'b0;
   logic         stats_clr = 1'b0;

   logic         in_ready, out_valid, err_flag;
   logic [127:0] out_data;
   logic [31:0]  toggle_cnt, word_cnt;

   logic         in_ready8, out_valid8, err_flag8;
   logic [127:0] out_data8;
   logic [7:0]   toggle_cnt8, word_cnt8;

   always #5 clk = ~clk;

   dbi_decode_128b #(.BW(128), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .dbi_en(dbi_en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .stats_clr(stats_clr), .toggle_cnt(toggle_cnt),
      .word_cnt(word_cnt), .err_flag(err_flag)
   );

   dbi_decode_128b #(.BW(128), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .dbi_en(dbi_en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
      .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready),
      .stats_clr(stats_clr), .toggle_cnt(toggle_cnt8),
      .word_cnt(word_cnt8), .err_flag(err_flag8)
   );

   // Reference model
   logic [127:0] q[$];
   logic [128:0] m_prev;
   longint       m_tog, m_word, m_tog8, m_word8;
   bit           m_err;
   int           checks = 0;
   int           errors = 0;

   localparam longint MAX32 = 64'hFFFF_FFFF;
   localparam longint MAX8  = 255;

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [128:0] rnd();
      return {1'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_all();
      chk("in_ready", 160'(in_ready), 160'(q.size() < 2));
      chk("out_valid", 160'(out_valid), 160'(q.size() > 0));
      if (q.size() > 0) chk("out_data", 160'(out_data), 160'(q[0]));
      chk("toggle_cnt", 160'(toggle_cnt), 160'(m_tog));
      chk("word_cnt", 160'(word_cnt), 160'(m_word));
      chk("err_flag", 160'(err_flag), 160'(m_err));
      chk("toggle_cnt8", 160'(toggle_cnt8), 160'(m_tog8));
      chk("word_cnt8", 160'(word_cnt8), 160'(m_word8));
      chk("out_valid8", 160'(out_valid8), 160'(q.size() > 0));
   endtask

   task automatic step(input bit v, input logic [128:0] d, input bit en,
                       input bit ordy, input bit clr);
      bit     acc, pop;
      longint pc;
      check_all();
      in_valid  = v;
      in_data   = d;
      dbi_en    = en;
      out_ready = ordy;
      stats_clr = clr;
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && ordy;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (clr) begin
         m_tog = 0; m_word = 0; m_tog8 = 0; m_word8 = 0; m_err = 0;
      end
      if (acc) begin
         q.push_back((en && d[128]) ? ~d[127:0] : d[127:0]);
         pc      = longint'($countones(d ^ m_prev));
         m_prev  = d;
         m_tog   = sat(m_tog + pc, MAX32);
         m_tog8  = sat(m_tog8 + pc, MAX8);
         m_word  = sat(m_word + 1, MAX32);
         m_word8 = sat(m_word8 + 1, MAX8);
         if (!en && d[128]) m_err = 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      stats_clr = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      q.delete();
      m_prev = '0;
      m_tog = 0; m_word = 0; m_tog8 = 0; m_word8 = 0; m_err = 0;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_out_valid", 160'(out_valid), 160'(0));
      chk("rst_in_ready", 160'(in_ready), 160'(1));
      chk("rst_out_data", 160'(out_data), 160'(0));
      chk("rst_toggle", 160'(toggle_cnt), 160'(0));
      chk("rst_word", 160'(word_cnt), 160'(0));
      chk("rst_err", 160'(err_flag), 160'(0));
   endtask

   logic [128:0] wa, wb, wc, w5, zero129, ones129;

   initial begin
      zero129 = '0;
      ones129 = '1;
      @(negedge clk);
      do_reset();

      // Basic decode
      step(1, {1'b1, 128'h0}, 1, 1, 0);
      chk("basic_inv", 160'(out_data), 160'({128{1'b1}}));
      step(1, {1'b0, {16{8'h5A}}}, 1, 1, 0);
      chk("basic_5a", 160'(out_data), 160'({16{8'h5A}}));
      step(0, zero129, 1, 1, 0);
      chk("basic_words", 160'(word_cnt), 160'(2));

      // Bypass and error
      step(1, {1'b0, {4{32'hDEADBEEF}}}, 0, 1, 0);
      chk("bypass_data", 160'(out_data), 160'({4{32'hDEADBEEF}}));
      step(1, {1'b1, 128'h0}, 0, 1, 0);
      chk("bypass_zero", 160'(out_data), 160'(0));
      chk("err_set", 160'(err_flag), 160'(1));
      step(0, zero129, 0, 1, 0);
      step(0, zero129, 0, 1, 0);
      chk("err_held", 160'(err_flag), 160'(1));
      step(0, zero129, 0, 1, 1);
      chk("err_clr", 160'(err_flag), 160'(0));

      // Backpressure
      wa = rnd(); wa[128] = 1'b0;
      wb = rnd(); wb[128] = 1'b0;
      wc = rnd(); wc[128] = 1'b0;
      step(1, wa, 1, 0, 0);
      step(1, wb, 1, 0, 0);
      chk("bp_full", 160'(in_ready), 160'(0));
      step(1, wc, 1, 0, 0);
      chk("bp_hold_a", 160'(out_data), 160'(wa[127:0]));
      step(1, wc, 1, 1, 0);
      chk("bp_b", 160'(out_data), 160'(wb[127:0]));
      step(1, wc, 1, 1, 0);
      chk("bp_c", 160'(out_data), 160'(wc[127:0]));
      step(0, zero129, 1, 1, 0);

      // Streaming with random data and flags
      step(0, zero129, 1, 1, 1);
      for (int i = 0; i < 100; i++) step(1, rnd(), 1, 1, 0);
      step(0, zero129, 1, 1, 0);
      chk("stream_words", 160'(word_cnt), 160'(100));

      // Saturation on the 8-bit instance, then clear with accept
      step(1, zero129, 1, 1, 1);
      step(1, ones129, 1, 1, 0);
      step(1, zero129, 1, 1, 0);
      step(1, ones129, 1, 1, 0);
      chk("sat8", 160'(toggle_cnt8), 160'(255));
      step(0, zero129, 1, 1, 0);
      chk("sat8_held", 160'(toggle_cnt8), 160'(255));
      w5 = ones129;
      w5[4:0] = 5'b0;
      step(1, w5, 1, 1, 1);
      chk("clr_tog", 160'(toggle_cnt), 160'(5));
      chk("clr_tog8", 160'(toggle_cnt8), 160'(5));
      chk("clr_word", 160'(word_cnt), 160'(1));

      // Mid-operation reset with two words buffered
      step(0, zero129, 1, 1, 0);
      step(1, rnd(), 1, 0, 0);
      step(1, rnd(), 1, 0, 0);
      chk("pre_rst_full", 160'(in_ready), 160'(0));
      do_reset();
      wa = rnd();
      step(1, wa, 1, 1, 0);
      chk("post_rst_tog", 160'(toggle_cnt), 160'($countones(wa)));
      step(0, zero129, 1, 1, 0);
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
